// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - tagged request FIFO and single-issue sequencer in front of the multicycle divider
module div_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_x,
  input  logic [WIDTH-1:0]           in_y,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_q,
  output logic [WIDTH-1:0]           out_r,
  output logic                       out_dbz,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       div_start,
  output logic [WIDTH-1:0]           div_x,
  output logic [WIDTH-1:0]           div_y,
  input  logic                       div_busy,
  input  logic                       div_valid,
  input  logic                       div_dbz,
  input  logic [WIDTH-1:0]           div_q,
  input  logic [WIDTH-1:0]           div_r,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_CHECK,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] fifo_x   [DEPTH];
  logic [WIDTH-1:0] fifo_y   [DEPTH];
  logic [TAG_W-1:0] fifo_tag [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_x;
  logic [TAG_W-1:0] op_tag;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             unused_busy;

  // Completion is judged from the sticky valid/dbz flags alone; busy carries no extra information here.
  assign unused_busy = div_busy;

  assign fifo_empty = (count == '0);
  assign in_ready   = (count != FULL_COUNT);
  assign fifo_count = count;
  assign push       = in_valid && in_ready;
  assign pop        = !fifo_empty && ((state == S_IDLE) || (state == S_HOLD && out_ready));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr]   <= in_x;
      fifo_y[wr_ptr]   <= in_y;
      fifo_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_x      <= '0;
      op_tag    <= '0;
      div_start <= 1'b0;
      div_x     <= '0;
      div_y     <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_dbz   <= 1'b0;
      out_tag   <= '0;
    end else begin
      // Issue happens from IDLE or straight out of HOLD, so the dequeue is shared by both.
      if (pop) begin
        op_x      <= fifo_x[rd_ptr];
        op_tag    <= fifo_tag[rd_ptr];
        div_x     <= fifo_x[rd_ptr];
        div_y     <= fifo_y[rd_ptr];
        div_start <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_START;
          end
        end
        S_START: begin
          div_start <= 1'b0;
          state     <= S_CHECK;
        end
        S_CHECK: begin
          if (div_dbz) begin
            out_q     <= '1;
            out_r     <= op_x;
            out_dbz   <= 1'b1;
            out_tag   <= op_tag;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (div_valid) begin
            out_q     <= div_q;
            out_r     <= div_r;
            out_dbz   <= 1'b0;
            out_tag   <= op_tag;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= pop ? S_START : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard bench for div_sequencer with a behavioural divider stand-in
module tb_div_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_y = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic             out_dbz;
  logic [TAG_W-1:0] out_tag;
  logic             div_start;
  logic [WIDTH-1:0] div_x;
  logic [WIDTH-1:0] div_y;
  logic             div_busy = 1'b0;
  logic             div_valid = 1'b0;
  logic             div_dbz = 1'b0;
  logic [WIDTH-1:0] div_q = '0;
  logic [WIDTH-1:0] div_r = '0;
  logic [$clog2(DEPTH):0] fifo_count;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   rand_mode = 1'b0;
  bit   held = 1'b0;
  exp_t h_data;
  exp_t mon_e;
  exp_t sb[$];

  logic [WIDTH-1:0] m_x = '0;
  logic [WIDTH-1:0] m_y = 8'd1;
  int               m_cnt = 0;

  div_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .out_dbz(out_dbz), .out_tag(out_tag),
    .div_start(div_start), .div_x(div_x), .div_y(div_y), .div_busy(div_busy),
    .div_valid(div_valid), .div_dbz(div_dbz), .div_q(div_q), .div_r(div_r),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider stand-in: no reset, start has priority, result after WIDTH cycles, flags sticky until next start.
  always @(posedge clk) begin
    if (div_start) begin
      m_x       <= div_x;
      m_y       <= div_y;
      div_valid <= 1'b0;
      if (div_y == '0) begin
        div_dbz  <= 1'b1;
        div_busy <= 1'b0;
      end else begin
        div_dbz  <= 1'b0;
        div_busy <= 1'b1;
        m_cnt    <= WIDTH;
      end
    end else if (div_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        div_busy  <= 1'b0;
        div_valid <= 1'b1;
        div_q     <= m_x / m_y;
        div_r     <= m_x % m_y;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) chk("hold_stable", {out_valid, out_q, out_r, out_dbz, out_tag}, {1'b1, h_data});
      if (out_valid && out_ready) begin
        held = 1'b0;
        chk("result_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("result", {out_q, out_r, out_dbz, out_tag}, mon_e);
        end
      end else if (out_valid) begin
        held   = 1'b1;
        h_data = {out_q, out_r, out_dbz, out_tag};
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [TAG_W-1:0] t);
    exp_t e;
    bit   acc = 1'b0;
    int   n = 0;
    e.tag = t;
    e.dbz = (y == '0);
    e.q   = (y == '0) ? '1 : x / y;
    e.r   = (y == '0) ? x : x % y;
    in_x = x;
    in_y = y;
    in_tag = t;
    in_valid = 1'b1;
    while (!acc && n < 3000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    last_acc = cyc;
    chk("push_accepted", 32'(acc), 32'd1);
    if (acc) sb.push_back(e);
  endtask

  task automatic wait_valid(input int p, output int lat);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 200);
    lat = cyc - p;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    int p0;
    int nr;
    int rise [4];
    logic pv;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] ry;

    idle(3);
    chk("rst_out", {out_valid, out_q, out_r, out_dbz, out_tag}, 32'd0);
    chk("rst_div", {div_start, div_x, div_y}, 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    idle(1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    push(8'd200, 8'd7, 4'd3);
    wait_valid(last_acc, lat);
    chk("lat_normal", lat, 32'd11);
    idle(3);

    push(8'd5, 8'd0, 4'd9);
    wait_valid(last_acc, lat);
    chk("lat_dbz", lat, 32'd3);
    idle(2);
    push(8'd255, 8'd1, 4'd10);
    wait_valid(last_acc, lat);
    chk("lat_after_dbz", lat, 32'd11);
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(8'(i * 37 + 11), 8'(i + 3), 4'(i));
      if (i == 0) p0 = last_acc;
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    wait_valid(p0, lat);
    chk("lat_first_queued", lat, 32'd11);
    idle(3);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("slot_freed_in_ready", 32'(in_ready), 32'd1);
    chk("slot_freed_count", 32'(fifo_count), 32'd3);
    push(8'd99, 8'd4, 4'd5);
    idle(4);
    out_ready = 1'b1;
    drain();
    idle(2);

    push(8'd0, 8'd9, 4'd0);
    p0 = last_acc;
    push(8'd100, 8'd10, 4'd1);
    push(8'd255, 8'd255, 4'd2);
    push(8'd17, 8'd3, 4'd3);
    nr = 0;
    pv = out_valid;
    for (int k = 0; k < 200 && nr < 4; k++) begin
      @(posedge clk);
      #1;
      if (out_valid && !pv) begin
        rise[nr] = cyc;
        nr++;
      end
      pv = out_valid;
    end
    chk("stream_rises", nr, 32'd4);
    chk("stream_lat0", rise[0] - p0, 32'd11);
    for (int k = 1; k < 4; k++) chk("stream_gap", rise[k] - rise[k-1], 32'd11);
    drain();
    idle(2);

    push(8'd100, 8'd3, 4'd1);
    push(8'd40, 8'd6, 4'd2);
    push(8'd9, 8'd2, 4'd3);
    idle(3);
    chk("pre_reset_count", 32'(fifo_count), 32'd2);
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_div_start", 32'(div_start), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(15);
    push(8'd50, 8'd7, 4'd4);
    wait_valid(last_acc, lat);
    chk("lat_post_reset", lat, 32'd11);
    drain();

    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rx = 8'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      push(rx, ry, 4'(i));
      if ($urandom_range(0, 9) == 0) idle(1);
    end
    drain();
    rand_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
